// File: rtl/car_ampl_pkg.sv
// Shared definitions for the carrier-amplitude scheduler: FSM encodings, midscale, default widths.
// The ramp feature is selected with CAR_AMPL_RAMP_EN in car_ampl_sched.
package car_ampl_pkg;

    localparam int unsigned DW_DEF   = 12;
    localparam int unsigned GW_DEF   = 8;
    localparam int unsigned MIDSCALE = 2048;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RAMP   = 2'd1;
    localparam logic [1:0] ST_MUTING = 2'd2;
    localparam logic [1:0] ST_MUTED  = 2'd3;

endpackage

// File: rtl/car_ampl_mult.sv
// Two-stage datapath: recentre the offset-binary sample, scale by gain/2^GW, re-offset and clamp.
module car_ampl_mult
    import car_ampl_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned GW = GW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [GW-1:0] gain,
    output logic [DW-1:0] dout
);

    localparam int unsigned PW = DW + GW + 1;
    localparam logic signed [PW-1:0] MID_P = PW'(MIDSCALE);
    localparam logic signed [PW-1:0] MAX_P = PW'((2 ** DW) - 1);

    logic signed [DW:0]    s_d, s_q;
    logic [GW-1:0]         g_d, g_q;
    logic signed [PW-1:0]  p, y_full;
    logic [DW-1:0]         y_d, y_q;

    // Gain is zero-extended so full scale stays positive; >>> floors toward -inf.
    always_comb begin
        s_d    = (DW+1)'({1'b0, din}) - (DW+1)'(MIDSCALE);
        g_d    = gain;
        p      = PW'(s_q) * signed'(PW'(g_q));
        y_full = (p >>> GW) + MID_P;
        if (y_full[PW-1]) begin
            y_d = '0;
        end else if (y_full > MAX_P) begin
            y_d = '1;
        end else begin
            y_d = y_full[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '0;
            g_q <= '0;
            y_q <= DW'(MIDSCALE);
        end else begin
            s_q <= s_d;
            g_q <= g_d;
            y_q <= y_d;
        end
    end

    assign dout = y_q;

endmodule

// File: rtl/car_ampl_sched.sv
// Carrier-amplitude scheduler: gain command handshake, ramp/mute FSM and scaled DAC output.
// Define CAR_AMPL_RAMP_EN for rate-limited ramps; otherwise transitions take a single clk.
module car_ampl_sched
    import car_ampl_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned GW       = GW_DEF,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned STEP     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [GW-1:0] cmd_gain,
    output logic          cmd_ready,
    input  logic          mute,
    input  logic [DW-1:0] dac_car,
    output logic [DW-1:0] dac_car_ampl,
    output logic [GW-1:0] gain_cur,
    output logic          busy
);

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] gain_q, gain_d;
    logic [GW-1:0] target_q, target_d;
    logic [GW-1:0] tgt;
    logic          accept;

    assign cmd_ready = ~mute & ((state_q == ST_IDLE) | (state_q == ST_RAMP));
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state_q == ST_RAMP) | (state_q == ST_MUTING);
    assign gain_cur  = gain_q;

`ifdef CAR_AMPL_RAMP_EN
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_q, tick_d;
    logic          tick;
    logic [GW-1:0] ramp_g, mute_g;

    // One ramp step from cur toward dst, landing exactly on dst when within STEP.
    function automatic logic [GW-1:0] step_toward(input logic [GW-1:0] cur, input logic [GW-1:0] dst);
        logic [GW-1:0] diff;
        step_toward = dst;
        if (cur < dst) begin
            diff = dst - cur;
            if (32'(diff) > STEP) step_toward = cur + GW'(STEP);
        end else begin
            diff = cur - dst;
            if (32'(diff) > STEP) step_toward = cur - GW'(STEP);
        end
    endfunction

    assign tick = (tick_q == TW'(TICK_DIV - 1));

    // Counter only runs while staying in a transition state, so every ramp starts a full period.
    always_comb begin
        tick_d = '0;
        if (((state_q == ST_RAMP) || (state_q == ST_MUTING)) &&
            ((state_d == ST_RAMP) || (state_d == ST_MUTING))) begin
            tick_d = tick ? '0 : tick_q + TW'(1);
        end
    end
`else
    // Rate parameters have no effect in the single-clk build.
    if ((TICK_DIV == 0) || (STEP == 0)) begin : g_rate_cfg_ignored
    end
`endif

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        target_d = target_q;
        tgt      = accept ? cmd_gain : target_q;
`ifdef CAR_AMPL_RAMP_EN
        ramp_g   = tick ? step_toward(gain_q, tgt) : gain_q;
        mute_g   = tick ? step_toward(gain_q, '0) : gain_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mute) begin
                    state_d = ST_MUTING;
                end else if (accept) begin
                    target_d = cmd_gain;
                    if (cmd_gain != gain_q) state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (mute) begin
                    state_d = ST_MUTING;
                end else begin
                    target_d = tgt;
`ifdef CAR_AMPL_RAMP_EN
                    gain_d = ramp_g;
                    if (ramp_g == tgt) state_d = ST_IDLE;
`else
                    gain_d  = tgt;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_MUTING: begin
                if (!mute) begin
                    state_d = (gain_q == target_q) ? ST_IDLE : ST_RAMP;
                end else begin
`ifdef CAR_AMPL_RAMP_EN
                    gain_d = mute_g;
                    if (mute_g == '0) state_d = ST_MUTED;
`else
                    gain_d  = '0;
                    state_d = ST_MUTED;
`endif
                end
            end
            ST_MUTED: begin
                if (!mute) state_d = (gain_q == target_q) ? ST_IDLE : ST_RAMP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gain_q   <= '0;
            target_q <= '0;
`ifdef CAR_AMPL_RAMP_EN
            tick_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            target_q <= target_d;
`ifdef CAR_AMPL_RAMP_EN
            tick_q   <= tick_d;
`endif
        end
    end

    car_ampl_mult #(
        .DW (DW),
        .GW (GW)
    ) u_mult (
        .clk  (clk),
        .rst  (rst),
        .din  (dac_car),
        .gain (gain_q),
        .dout (dac_car_ampl)
    );

endmodule

// File: tb/tb_car_ampl_sched.sv
// Directed bench for car_ampl_sched; output samples are checked through a 2-deep expected queue.
module tb_car_ampl_sched;

    localparam int unsigned DW       = 12;
    localparam int unsigned GW       = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned STEP     = 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic [GW-1:0] cmd_gain;
    logic          cmd_ready;
    logic          mute;
    logic [DW-1:0] dac_car;
    logic [DW-1:0] dac_car_ampl;
    logic [GW-1:0] gain_cur;
    logic          busy;

    int            n_checks;
    int            n_err;
    logic [GW-1:0] exp_gain;
    logic [DW-1:0] sb[$];

    car_ampl_sched #(
        .DW       (DW),
        .GW       (GW),
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_gain     (cmd_gain),
        .cmd_ready    (cmd_ready),
        .mute         (mute),
        .dac_car      (dac_car),
        .dac_car_ampl (dac_car_ampl),
        .gain_cur     (gain_cur),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] d, input logic [GW-1:0] g);
        int s, p, y;
        s = int'(d) - 2048;
        p = s * int'(g);
        y = (p >>> 8) + 2048;
        if (y < 0) y = 0;
        if (y > 4095) y = 4095;
        return DW'(y);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk: queue the expected output for the current inputs, then check state after the edge.
    task automatic cycle(input logic [GW-1:0] g, input logic b);
        logic [DW-1:0] e;
        sb.push_back(ref_out(dac_car, exp_gain));
        @(posedge clk);
        #1;
        exp_gain = g;
        e = sb.pop_front();
        chk("gain_cur", 32'(gain_cur), 32'(g));
        chk("busy", 32'(busy), 32'(b));
        chk("dac_car_ampl", 32'(dac_car_ampl), 32'(e));
    endtask

    // Cycles after entering RAMP/MUTING from a settled state until the gain lands on to_g.
    task automatic settle(input logic [GW-1:0] to_g);
`ifdef CAR_AMPL_RAMP_EN
        int n, k, cnt, from;
        from = int'(exp_gain);
        n    = (int'(to_g) > from) ? int'(to_g) - from : from - int'(to_g);
        k    = 0;
        cnt  = 0;
        while (cnt < n) begin
            k++;
            cnt = k / int'(TICK_DIV);
            cycle((int'(to_g) > from) ? GW'(from + cnt) : GW'(from - cnt), cnt < n);
        end
`else
        cycle(to_g, 1'b0);
`endif
    endtask

    task automatic cmd(input logic [GW-1:0] g);
        logic [GW-1:0] s;
        s = exp_gain;
        cmd_valid = 1'b1;
        cmd_gain  = g;
        #1;
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        if (g == s) begin
            cycle(s, 1'b0);
            cmd_valid = 1'b0;
        end else begin
            cycle(s, 1'b1);
            cmd_valid = 1'b0;
            settle(g);
        end
    endtask

    task automatic mute_on();
        mute = 1'b1;
        #1;
        chk("cmd_ready_muting", 32'(cmd_ready), 32'd0);
        cycle(exp_gain, 1'b1);
        settle('0);
    endtask

    task automatic mute_off(input logic [GW-1:0] tgt);
        mute = 1'b0;
        cycle('0, 1'b1);
        settle(tgt);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_gain  = '0;
        mute      = 1'b0;
        dac_car   = 12'd4095;
        exp_gain  = '0;

        #12;
        chk("rst_dac_car_ampl", 32'(dac_car_ampl), 32'd2048);
        chk("rst_gain_cur", 32'(gain_cur), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back(12'd2048);

        cmd(8'd10);
        cycle(8'd10, 1'b0);

        cmd(8'd128);
        repeat (3) cycle(8'd128, 1'b0);
        dac_car = 12'd0;
        repeat (2) cycle(8'd128, 1'b0);
        cmd(8'd255);
        repeat (3) cycle(8'd255, 1'b0);
        dac_car = 12'd2048;
        cycle(8'd255, 1'b0);
        dac_car = 12'd1;
        cycle(8'd255, 1'b0);
        dac_car = 12'd3000;
        cycle(8'd255, 1'b0);
        cmd(8'd255);

        cmd(8'd200);
        dac_car = 12'd4095;
        mute_on();
        repeat (3) cycle('0, 1'b0);
        dac_car = 12'd0;
        cmd_valid = 1'b1;
        cmd_gain  = 8'd7;
        #1;
        chk("cmd_ready_muted", 32'(cmd_ready), 32'd0);
        repeat (3) cycle('0, 1'b0);
        cmd_valid = 1'b0;
        dac_car = 12'd4095;
        mute_off(8'd200);
        cycle(8'd200, 1'b0);

        mute      = 1'b1;
        cmd_valid = 1'b1;
        cmd_gain  = 8'd50;
        #1;
        chk("cmd_ready_same_clk", 32'(cmd_ready), 32'd0);
        cycle(8'd200, 1'b1);
        cmd_valid = 1'b0;
        settle('0);
        mute_off(8'd200);
        chk("target_kept", 32'(gain_cur), 32'd200);

`ifdef CAR_AMPL_RAMP_EN
        cmd(8'd0);
        cmd_valid = 1'b1;
        cmd_gain  = 8'd200;
        cycle('0, 1'b1);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 200; k++) cycle(GW'(k / int'(TICK_DIV)), 1'b1);
        mute = 1'b1;
        #1;
        chk("cmd_ready_midramp", 32'(cmd_ready), 32'd0);
        cycle(8'd50, 1'b1);
        begin
            int k, cnt;
            k   = 0;
            cnt = 0;
            while (cnt < 50) begin
                k++;
                cnt = (1 + k) / int'(TICK_DIV);
                cycle(GW'(50 - cnt), cnt < 50);
            end
        end
        repeat (2) cycle('0, 1'b0);
        mute_off(8'd200);
`endif

        cmd_valid = 1'b1;
        cmd_gain  = 8'd100;
        cycle(8'd200, 1'b1);
        cmd_valid = 1'b0;
        rst = 1'b0;
        #2;
        chk("midrst_gain_cur", 32'(gain_cur), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dac_car_ampl", 32'(dac_car_ampl), 32'd2048);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        sb.push_back(12'd2048);
        exp_gain = '0;
        repeat (3) cycle('0, 1'b0);
        cmd(8'd64);
        repeat (3) cycle(8'd64, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
